// File: rtl/nios2_debug_pkg.sv
// Shared encodings for the Nios II debug access scheduler: access-port target
// select, FSM states and the jdo command-word field layout.
package nios2_debug_pkg;

  localparam int JDO_W        = 38;
  localparam int JDO_WR_BIT   = 37;
  localparam int JDO_ADDR_LSB = 32;
  localparam int JDO_ADDR_W   = 5;
  localparam int JDO_DATA_LSB = 0;
  localparam int JDO_DATA_W   = 32;

  typedef enum logic [1:0] {
    SEL_OCIMEM   = 2'b00,
    SEL_TRACEMEM = 2'b01,
    SEL_BREAK    = 2'b10
  } acc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ISSUE    = 2'b01,
    ST_WAIT_RSP = 2'b10,
    ST_DONE     = 2'b11
  } dbg_state_e;

  // Requester index order is ocimem=0, tracemem=1, break=2.
  function automatic acc_sel_e sel_from_onehot(input logic [2:0] g);
    case (g)
      3'b010:  return SEL_TRACEMEM;
      3'b100:  return SEL_BREAK;
      default: return SEL_OCIMEM;
    endcase
  endfunction

endpackage

// File: rtl/nios2_dbg_rr_arb3.sv
// Three-way round-robin arbiter; the granted requester drops to lowest
// priority once the grant is accepted.
module nios2_dbg_rr_arb3 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] req_i,
  input  logic       accept_i,
  output logic [2:0] gnt_o
);

  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    gnt_o = 3'b000;
    case (ptr_q)
      2'd1: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      2'd2: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      if (gnt_o[0])      ptr_d = 2'd1;
      else if (gnt_o[1]) ptr_d = 2'd2;
      else if (gnt_o[2]) ptr_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= 2'd0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/nios2_debug_access_sched.sv
// Serialises ocimem / tracemem / break debug commands onto one shared access
// port, with per-requester one-deep buffering and a transaction timeout.
module nios2_debug_access_sched
  import nios2_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_ocimem_i,
  input  logic             req_tracemem_i,
  input  logic             req_break_i,
  input  logic [JDO_W-1:0] jdo_i,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [1:0]       acc_sel_o,
  output logic             acc_write_o,
  output logic [4:0]       acc_addr_o,
  output logic [31:0]      acc_wdata_o,
  input  logic             rsp_valid_i,
  input  logic [31:0]      rsp_rdata_i,
  output logic [31:0]      mon_rdata_o,
  output logic             mon_ready_o,
  output logic             mon_error_o,
  output logic             req_drop_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  dbg_state_e       state_q, state_d;
  logic [2:0]       stb, clr, drop, gnt, gnt_q, gnt_d, pend_q, pend_d;
  logic [JDO_W-1:0] cmd_q [3];
  logic [JDO_W-1:0] cmd_d [3];
  logic [JDO_W-1:0] gnt_cmd;
  logic [15:0]      tmr_q, tmr_d;
  logic             abort_q, abort_d, grant, timeout;
  logic [1:0]       sel_q, sel_d;
  logic             wr_q, wr_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic             ready_q, ready_d, error_q, error_d, drop_q;

  assign stb     = {req_break_i, req_tracemem_i, req_ocimem_i};
  assign clr     = (state_q == ST_DONE) ? gnt_q : 3'b000;
  assign grant   = (state_q == ST_IDLE) && (|pend_q);
  assign timeout = (tmr_q == TMO_LAST);
  assign gnt_cmd = gnt[2] ? cmd_q[2] : (gnt[1] ? cmd_q[1] : cmd_q[0]);

  nios2_dbg_rr_arb3 u_arb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .req_i    (pend_q),
    .accept_i (grant),
    .gnt_o    (gnt)
  );

  // A strobe landing on the cycle its flag clears is accepted (set wins).
  always_comb begin
    pend_d = pend_q;
    drop   = 3'b000;
    for (int i = 0; i < 3; i++) cmd_d[i] = cmd_q[i];
    for (int i = 0; i < 3; i++) begin
      if (clr[i]) pend_d[i] = 1'b0;
      if (stb[i]) begin
        if (!pend_q[i] || clr[i]) begin
          pend_d[i] = 1'b1;
          cmd_d[i]  = jdo_i;
        end else begin
          drop[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    tmr_d   = tmr_q;
    abort_d = abort_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_ISSUE;
          gnt_d   = gnt;
          tmr_d   = 16'd0;
          abort_d = 1'b0;
          sel_d   = sel_from_onehot(gnt);
          wr_d    = gnt_cmd[JDO_WR_BIT];
          addr_d  = gnt_cmd[JDO_ADDR_LSB +: JDO_ADDR_W];
          wdata_d = gnt_cmd[JDO_DATA_LSB +: JDO_DATA_W];
          ready_d = 1'b0;
          error_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        tmr_d = tmr_q + 16'd1;
        if (acc_ready_i) begin
          state_d = wr_q ? ST_DONE : ST_WAIT_RSP;
        end else if (timeout) begin
          state_d = ST_DONE;
          abort_d = 1'b1;
        end
      end
      ST_WAIT_RSP: begin
        tmr_d = tmr_q + 16'd1;
        if (rsp_valid_i) begin
          rdata_d = rsp_rdata_i;
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d = ST_DONE;
          abort_d = 1'b1;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        error_d = abort_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      pend_q  <= 3'b000;
      for (int i = 0; i < 3; i++) cmd_q[i] <= '0;
      gnt_q   <= 3'b000;
      tmr_q   <= 16'd0;
      abort_q <= 1'b0;
      sel_q   <= 2'b00;
      wr_q    <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      for (int i = 0; i < 3; i++) cmd_q[i] <= cmd_d[i];
      gnt_q   <= gnt_d;
      tmr_q   <= tmr_d;
      abort_q <= abort_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      drop_q  <= |drop;
    end
  end

  assign acc_valid_o = (state_q == ST_ISSUE);
  assign acc_sel_o   = sel_q;
  assign acc_write_o = wr_q;
  assign acc_addr_o  = addr_q;
  assign acc_wdata_o = wdata_q;
  assign mon_rdata_o = rdata_q;
  assign mon_ready_o = ready_q;
  assign mon_error_o = error_q;
  assign req_drop_o  = drop_q;

endmodule

// File: doc/nios2_debug_access_sched.md
NIOS2_DEBUG_ACCESS_SCHED -- requirements
Module: nios2_debug_access_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles from entry into ISSUE to completion before an error abort; legal range 1-65535.
REQ-002 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_ocimem, req_tracemem, req_break  in  1 each  single-cycle action strobes.
REQ-005 jdo  in  38  command word, sampled with any strobe: [37] write flag, [36:32] address, [31:0] write data.
REQ-006 acc_valid  out  1  shared access-port request.
REQ-007 acc_ready  in  1  port accepts the request.
REQ-008 acc_sel  out  2  target: 00 ocimem, 01 tracemem, 10 break.
REQ-009 acc_write  out  1  write flag.
REQ-010 acc_addr  out  5  address.
REQ-011 acc_wdata  out  32  write data.
REQ-012 rsp_valid  in  1  read data valid.
REQ-013 rsp_rdata  in  32  read data.
REQ-014 mon_rdata  out  32  last read result.
REQ-015 mon_ready  out  1  last access complete.
REQ-016 mon_error  out  1  last access timed out.
REQ-017 req_drop  out  1  one-cycle pulse: a strobe was discarded.

Function
REQ-018 Each requester SHALL have a one-deep pending flag plus a 38-bit command register loaded from jdo on its strobe when the flag is clear.
REQ-019 A strobe arriving while its flag is set and not being cleared that cycle SHALL be dropped: command register unchanged, req_drop high the next cycle.
REQ-020 A strobe in the same cycle as its flag clears (DONE) SHALL be accepted; set wins.
REQ-021 Simultaneous strobes from different requesters SHALL all be latched.
REQ-022 The FSM SHALL have the states IDLE, ISSUE, WAIT_RSP and DONE.
REQ-023 IDLE: if any flag is set, grant one requester round-robin, copy its command to the acc_* outputs and go to ISSUE; otherwise stay in IDLE.
REQ-024 Round-robin: the pointer after reset favours ocimem, then tracemem, then break; after a grant the granted requester becomes lowest priority.
REQ-025 ISSUE: acc_valid=1 and acc_* SHALL be stable until acc_ready=1.
REQ-026 On acc_ready in ISSUE: write goes to DONE, read goes to WAIT_RSP.
REQ-027 WAIT_RSP: on rsp_valid, capture rsp_rdata into mon_rdata and go to DONE; rsp_valid in any other state SHALL be ignored.
REQ-028 DONE lasts one cycle, SHALL clear the granted flag and set mon_ready, sets mon_error to the abort status, then returns to IDLE.
REQ-029 mon_ready and mon_error SHALL clear on the cycle of the next grant.
REQ-030 Timeout counter: 16 bits, zeroed on entry to ISSUE, increments in ISSUE and WAIT_RSP; on reaching TIMEOUT_CYCLES it SHALL force DONE with mon_error=1, mon_rdata unchanged, acc_valid dropped.
REQ-031 Minimum latency: strobe at edge N -> flag set at N+1 -> acc_valid visible after edge N+2.

Reset
REQ-032 Reset, including mid-operation, SHALL return the FSM to IDLE and clear all pending flags and the timeout counter.
REQ-033 Reset SHALL drive acc_valid=0, acc_sel=00, acc_write=0, acc_addr=0, acc_wdata=0, mon_rdata=0, mon_ready=0, mon_error=0, req_drop=0.
REQ-034 Reset SHALL point the round-robin at ocimem; any in-flight response after reset SHALL be ignored.

Structure
REQ-035 The acc_sel encodings, FSM state encoding, and the jdo field positions/widths SHALL live in a shared package nios2_debug_pkg.
REQ-036 Round-robin grant logic SHALL be a sub-module nios2_dbg_rr_arb3 (3 request bits in, one-hot grant out, pointer update on an accept strobe).

Verification
REQ-037 Write sequence: req_ocimem with jdo={1,5'h03,32'h1234_5678}, acc_ready=1 -> acc_valid after 2 edges, acc_sel=00, acc_addr=3, acc_wdata=32'h12345678; mon_ready=1 three cycles later.
REQ-038 Read sequence: req_tracemem read of address 7; rsp_valid with rsp_rdata=32'hCAFE_0001 two cycles after acceptance -> mon_rdata=32'hCAFE0001, mon_ready=1, mon_error=0.
REQ-039 Simultaneous strobes: all three in one cycle, acc_ready=1 -> grant order 00,01,10; a second burst after that -> order 00,01,10 again.
REQ-040 Drop case: req_break twice, 1 cycle apart, acc_ready held 0 -> one req_drop pulse; the first command is issued.
REQ-041 Timeout: TIMEOUT_CYCLES=4, acc_ready=0 -> acc_valid drops and mon_error=1 after 4 ISSUE cycles; mon_rdata unchanged.
REQ-042 Mid-operation reset: reset asserted in WAIT_RSP, then rsp_valid pulsed -> all outputs at reset values; no mon_ready.
